// File: rtl/mem_arbiter_pkg.sv
// Shared types, port ids and the round-robin pick used by the memory arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM: one transaction outstanding at a time.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWaitI = 2'd1,
        StWaitD = 2'd2
    } state_e;

    // Port ids, also the encoding of the last_grant bit.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Contested grants go to the port not served last; a lone requester always wins.
    function automatic logic rr_pick(input logic i_pend, input logic d_pend,
                                     input logic last_grant);
        logic pick;
        if (i_pend && d_pend) begin
            pick = ~last_grant;
        end else if (d_pend) begin
            pick = PORT_D;
        end else begin
            pick = PORT_I;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter_req_latch.sv
// Per-port request holder: pending bit plus payload captured on the request pulse.
module mem_arbiter_req_latch
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_SCALE = 27
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 set,
    input  logic                 clr,
    input  logic [MEM_SCALE-1:0] set_addr,
    input  logic [3:0]           set_we,
    input  logic [31:0]          set_wdata,
    output logic                 pending,
    output logic [MEM_SCALE-1:0] addr,
    output logic [3:0]           we,
    output logic [31:0]          wdata
);

    logic                 pending_q;
    logic [MEM_SCALE-1:0] addr_q;
    logic [3:0]           we_q;
    logic [31:0]          wdata_q;

    // Pending bit: set by an accepted request, cleared in the cycle the port is granted.
    // The caller never sets a port that is already pending, so set and clr never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
        end else if (set) begin
            pending_q <= 1'b1;
        end else if (clr) begin
            pending_q <= 1'b0;
        end
    end

    // Payload is captured with the request and held until the next accepted request,
    // so it stays valid on the memory bus for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
        end else if (set) begin
            addr_q  <= set_addr;
            we_q    <= set_we;
            wdata_q <= set_wdata;
        end
    end

    assign pending = pending_q;
    assign addr    = addr_q;
    assign we      = we_q;
    assign wdata   = wdata_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between the ICACHE refill port and the DCACHE load/store port
// onto a single DRAM controller port, one transaction in flight at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_SCALE = 27,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // instruction refill side
    input  logic                 i_oe,
    input  logic [MEM_SCALE-1:0] i_addr,
    output logic [31:0]          i_rdata,
    output logic                 i_valid,
    // data side
    input  logic                 d_oe,
    input  logic [3:0]           d_we,
    input  logic [MEM_SCALE-1:0] d_addr,
    input  logic [31:0]          d_wdata,
    output logic [31:0]          d_rdata,
    output logic                 d_valid,
    // DRAM controller side
    output logic                 mem_oe,
    output logic [3:0]           mem_we,
    output logic [MEM_SCALE-1:0] mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic                 mem_ready,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_valid,
    // status
    output logic                 proto_err,
    output logic [CNT_WIDTH-1:0] cnt_i_wait,
    output logic [CNT_WIDTH-1:0] cnt_d_wait
);

    state_e               state_q;
    logic                 last_grant_q;
    logic                 proto_err_q;
    logic [CNT_WIDTH-1:0] cnt_i_q;
    logic [CNT_WIDTH-1:0] cnt_d_q;

    logic                 i_pend;
    logic                 d_pend;
    logic [MEM_SCALE-1:0] i_lat_addr;
    logic [MEM_SCALE-1:0] d_lat_addr;
    logic [3:0]           i_lat_we;
    logic [3:0]           d_lat_we;
    logic [31:0]          i_lat_wdata;
    logic [31:0]          d_lat_wdata;

    logic i_busy;
    logic d_busy;
    logic i_set;
    logic d_set;
    logic i_err;
    logic d_err;
    logic i_clr;
    logic d_clr;
    logic grant;
    logic grant_port;
    logic sel_port;
    logic idle_resp;

    // Request acceptance, error detection and grant decision.
    always_comb begin
        // A port is busy while pending or in flight; its completing cycle is free again.
        i_busy     = i_pend || (state_q == StWaitI && !mem_valid);
        d_busy     = d_pend || (state_q == StWaitD && !mem_valid);
        i_set      = i_oe && !i_busy;
        d_set      = d_oe && !d_busy;
        i_err      = i_oe && i_busy;
        d_err      = d_oe && d_busy;
        idle_resp  = mem_valid && (state_q == StIdle);

        grant      = (state_q == StIdle) && mem_ready && (i_pend || d_pend);
        grant_port = rr_pick(i_pend, d_pend, last_grant_q);
        i_clr      = grant && (grant_port == PORT_I);
        d_clr      = grant && (grant_port == PORT_D);

        // Bus payload follows the grant in IDLE and the owning port while in flight.
        case (state_q)
            StWaitI: sel_port = PORT_I;
            StWaitD: sel_port = PORT_D;
            default: sel_port = grant_port;
        endcase
    end

    mem_arbiter_req_latch #(
        .MEM_SCALE (MEM_SCALE)
    ) u_req_latch_i (
        .clk       (clk),
        .rst_n     (rst_n),
        .set       (i_set),
        .clr       (i_clr),
        .set_addr  (i_addr),
        .set_we    (4'b0000),
        .set_wdata (32'h0000_0000),
        .pending   (i_pend),
        .addr      (i_lat_addr),
        .we        (i_lat_we),
        .wdata     (i_lat_wdata)
    );

    mem_arbiter_req_latch #(
        .MEM_SCALE (MEM_SCALE)
    ) u_req_latch_d (
        .clk       (clk),
        .rst_n     (rst_n),
        .set       (d_set),
        .clr       (d_clr),
        .set_addr  (d_addr),
        .set_we    (d_we),
        .set_wdata (d_wdata),
        .pending   (d_pend),
        .addr      (d_lat_addr),
        .we        (d_lat_we),
        .wdata     (d_lat_wdata)
    );

    // Transaction FSM and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= PORT_D;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant) begin
                        last_grant_q <= grant_port;
                        state_q      <= (grant_port == PORT_I) ? StWaitI : StWaitD;
                    end
                end
                StWaitI, StWaitD: begin
                    if (mem_valid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Sticky protocol error: overlapping request on a port, or a response with nothing open.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_q <= 1'b0;
        end else if (i_err || d_err || idle_resp) begin
            proto_err_q <= 1'b1;
        end
    end

    // Wait counters: every cycle a port is pending, including its grant cycle; wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_i_q <= '0;
            cnt_d_q <= '0;
        end else begin
            if (i_pend) begin
                cnt_i_q <= cnt_i_q + CNT_WIDTH'(1);
            end
            if (d_pend) begin
                cnt_d_q <= cnt_d_q + CNT_WIDTH'(1);
            end
        end
    end

    // Memory request and response routing.
    always_comb begin
        mem_oe     = grant;
        mem_addr   = (sel_port == PORT_D) ? d_lat_addr  : i_lat_addr;
        mem_we     = (sel_port == PORT_D) ? d_lat_we    : i_lat_we;
        mem_wdata  = (sel_port == PORT_D) ? d_lat_wdata : i_lat_wdata;
        i_valid    = mem_valid && (state_q == StWaitI);
        d_valid    = mem_valid && (state_q == StWaitD);
        i_rdata    = mem_rdata;
        d_rdata    = mem_rdata;
        proto_err  = proto_err_q;
        cnt_i_wait = cnt_i_q;
        cnt_d_wait = cnt_d_q;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter between the cache refill ports and the single DRAM controller port. The instruction side takes the ICACHE refill interface (one-cycle read pulse, address held, data plus one-cycle valid back). The data side takes the DCACHE/uncached load-store port. Requests are latched, granted round-robin, and issued one at a time; each response is routed back to the port that owns the outstanding transaction.

## Interface
Parameters:
- MEM_SCALE, 27, word-address width shared with the caches
- CNT_WIDTH, 32, width of the statistics counters

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_oe  in  1  instruction refill request pulse (ICACHE super_oe)
- i_addr  in  MEM_SCALE  refill word address, sampled when i_oe=1
- i_rdata  out  32  refill data (mem_rdata pass-through)
- i_valid  out  1  refill data valid, one cycle
- d_oe  in  1  data request pulse
- d_we  in  4  byte write enables; 0 means read, sampled with d_oe
- d_addr  in  MEM_SCALE  data word address, sampled with d_oe
- d_wdata  in  32  write data, sampled with d_oe
- d_rdata  out  32  read data (mem_rdata pass-through)
- d_valid  out  1  read data valid or write ack, one cycle
- mem_oe  out  1  DRAM request strobe
- mem_we  out  4  DRAM byte enables
- mem_addr  out  MEM_SCALE  DRAM word address
- mem_wdata  out  32  DRAM write data
- mem_ready  in  1  controller accepts mem_oe this cycle
- mem_rdata  in  32  DRAM read data
- mem_valid  in  1  DRAM response, one cycle; also acks writes
- proto_err  out  1  sticky protocol-error flag
- cnt_i_wait, cnt_d_wait  out  CNT_WIDTH  cycles each port spent pending but not yet granted

## Operation
- Per port, the block holds a pending bit plus latched address, we and wdata (data side only). x_oe sets the pending bit and the latch. The bit clears in the cycle that port is granted.
- FSM states:
  - IDLE: if any pending bit is set and mem_ready=1, assert mem_oe with the granted port's latch and go to WAIT_I or WAIT_D.
  - WAIT_I / WAIT_D: hold until mem_valid=1, then return to IDLE.
- Arbitration is round-robin. A last_grant bit favours the port not served last. With only one port pending, that port wins regardless. last_grant resets to D, so I wins the first tie.
- Responses: i_valid = mem_valid && state==WAIT_I. d_valid = mem_valid && state==WAIT_D. i_rdata and d_rdata both equal mem_rdata.
- For instruction requests, mem_we = 0 and mem_wdata = 0.
- Errors set proto_err, which clears only on reset:
  - x_oe while that port is already pending or in flight: the request is ignored.
  - mem_valid in IDLE: the response is ignored and no valid is raised.
- Wait counters increment each cycle the port's pending bit is set. They wrap modulo 2^CNT_WIDTH.

## Timing
- Reset values:
  - State IDLE; pending bits 0; last_grant=D.
  - mem_oe=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - i_valid=0, d_valid=0, proto_err=0, counters 0.
- Handshake timing:
  - x_oe at cycle t gives mem_oe at the earliest in cycle t+1.
  - mem_oe is combinational from state, pending bits and mem_ready. mem_addr, mem_we and mem_wdata come from registers.
  - mem_valid at cycle k gives x_valid in cycle k, zero latency.
  - The next mem_oe is possible at cycle k+1.
- Minimum read round trip is 1 + DRAM latency cycles. Throughput is one transaction per DRAM round trip.
- Simultaneous events:
  - i_oe and d_oe in the same cycle: both latch; round-robin picks.
  - x_oe in the cycle mem_valid completes that same port's transaction: accepted, not an error.
  - mem_ready=0 in IDLE: hold pending and keep mem_oe=0.
- Reset mid-transaction drops all pending and in-flight work. A mem_valid arriving after reset hits IDLE and flags proto_err.

## Structure
- Shared package holds the state encoding (IDLE, WAIT_I, WAIT_D) and the port id constants (PORT_I=0, PORT_D=1).
- One sub-module, req_latch: the pending bit plus payload register with a set-on-pulse / clear-on-grant interface. It is instantiated twice, with wdata and we tied off on the I side.
- Counters and FSM are in the top module.

## Test plan
- Single I read at 0x0000123, 3-cycle DRAM latency:
  - mem_oe one cycle after i_oe with mem_addr=0x0000123 and mem_we=0.
  - i_valid for one cycle with i_rdata=mem_rdata; d_valid stays 0.
- D write at addr 0x10, d_we=4'b0011, wdata 0xDEADBEEF:
  - mem_we=0011, mem_wdata=0xDEADBEEF.
  - d_valid on mem_valid.
- i_oe and d_oe in the same cycle after reset: I is granted first and D second. D completes one DRAM round trip later, and cnt_d_wait increments for each cycle D waits.
- Back-to-back contention with 10 alternating requests per port: grants alternate I, D, I, D…; no port is granted twice in a row while the other is pending.
- mem_ready held 0 for 5 cycles with I pending:
  - mem_oe stays 0, then fires on the first ready cycle.
  - cnt_i_wait increases by 6.
- Error cases:
  - Second i_oe while WAIT_I: proto_err=1, and only one mem_oe is issued.
  - rst_n pulsed mid-WAIT_D: outputs return to reset values; the late mem_valid produces no d_valid and sets proto_err.
